adder_tree_acc: RTL and testbench
=================================

Name: adder_tree_acc

Overview:
- Parametrised, fully pipelined unsigned adder tree. Reduces NUM_IN lanes of IN_W bits to one sum per beat.
- Adds valid tagging, an optional multi-beat accumulation mode, saturation with an overflow flag, and a synchronous flush.
- Next-generation reduction engine for the compute datapath. Sums per-lane weight/term products into one partial-product result per output.

Parameters:
- NUM_IN, 32, number of input lanes; power of two, 2..256.
- IN_W, 4, width of each unsigned input lane.
- ACC_W, 16, accumulator/output width; must be >= TREE_W.
- Derived: LEVELS = log2(NUM_IN); TREE_W = IN_W + LEVELS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*IN_W  packed lanes; lane k = bits [k*IN_W +: IN_W].
- in_valid  in  1  beat qualifier.
- in_acc  in  1  beat belongs to an accumulation group; sampled with in_valid.
- in_last  in  1  final beat of a group; ignored when in_acc=0.
- clr  in  1  synchronous flush.
- out_sum  out  ACC_W  result.
- out_valid  out  1  one-cycle pulse; out_sum/out_ovf valid.
- out_ovf  out  1  result saturated.
- busy  out  1  any valid beat in flight, or accumulation group open.

Behaviour:
- Reset (async, rst_n=0):
  - All stage registers, valid/acc/last tags, accumulator and group-open flag cleared.
  - out_sum=0, out_valid=0, out_ovf=0, busy=0.
- Tree:
  - LEVELS registered stages. Stage s holds NUM_IN>>s sums of width IN_W+s.
  - Pairing is adjacent: stage-1 sum j = lane 2j + lane 2j+1.
  - Zero-extend operands before each add; no truncation inside the tree.
- Tags:
  - valid, acc and last shift alongside the data, one register per stage.
  - Invalid beats are bubbles. Their data is don't-care and must never reach the accumulator.
- Output stage, one register after the tree. Total latency = LEVELS+1 cycles from in_valid to out_valid (6 at defaults).
  - Tagged acc=0: out_sum = zero-extended tree sum; out_valid=1; out_ovf=0. Accumulator is untouched.
  - Tagged acc=1, last=0: acc <= sat(acc + tree); group-open=1; no out_valid.
  - Tagged acc=1, last=1: out_sum = sat(acc + tree); out_valid=1; out_ovf = sticky overflow of the group; then acc<=0, group-open=0, ovf<=0.
  - sat(): clamp to 2^ACC_W-1 and set sticky ovf. Once saturated, the accumulator stays saturated for the rest of the group.
- Non-accumulate beat arriving while a group is open:
  - Its result is emitted normally.
  - The open group's accumulator is preserved. Interleaving is legal.
- out_valid pulses exactly one cycle per completed result. out_sum holds its last value between pulses.
- clr=1 at a clock edge:
  - All pipeline valid tags, accumulator, group-open and sticky ovf cleared.
  - A beat presented on in_valid in the same cycle is dropped.
  - out_valid=0 in the following cycle. out_sum keeps its last value.
- busy = OR of all stage valid tags OR group-open. Combinational from registers.
- Throughput: one beat per cycle, no backpressure. The consumer must accept every out_valid.
- Asserting rst_n mid-group discards the group; no output is produced for it.

Test Plan:
- Single beat, defaults, all 32 lanes = 4'hF, in_acc=0 -> out_valid after 6 cycles; out_sum=480; out_ovf=0.
- Streaming: 10 consecutive valid beats, lane k = (beat+k)%16 -> 10 consecutive out_valid pulses with matching reference sums; no gaps or duplicates. A bubble inserted mid-stream -> corresponding one-cycle gap in out_valid.
- Accumulate group: 3 beats of all-lanes=1 with in_acc=1, in_last on the 3rd -> one out_valid; out_sum=96. Then a single acc=0 beat of all-lanes=2 -> out_sum=64.
- Saturation, ACC_W=10: group of 3 beats of all-lanes=15 (3*480=1440 > 1023) -> out_sum=1023, out_ovf=1. Next group of 1 beat all-lanes=1 with in_last -> out_sum=32, out_ovf=0.
- Flush: start a group of 2 beats, assert clr for one cycle before the last beat exits; send a new 1-beat group all-lanes=1 -> only 32 emitted; no out_valid for the flushed beats; busy falls to 0 after the clr edge.
- Reset mid-pipeline: drop rst_n with 4 beats in flight -> out_valid, out_sum, busy = 0 immediately; no stale output after release. Repeat with NUM_IN=8, IN_W=6 -> latency 4 and correct sums.

Source files
------------

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined unsigned adder tree with valid/acc/last tagging,
// optional multi-beat accumulation with saturation, and a synchronous flush.
// Latency from in_valid to out_valid is LEVELS+1 cycles.
module adder_tree_acc #(
  parameter int NUM_IN = 32,
  parameter int IN_W   = 4,
  parameter int ACC_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_acc,
  input  logic                   in_last,
  input  logic                   clr,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_valid,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int LEVELS = $clog2(NUM_IN);
  localparam int TREE_W = IN_W + LEVELS;

  // Saturating add: returns {overflow, clamped sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = s;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reduction tree: stage s holds NUM_IN>>s sums of IN_W+s bits, adjacent
  // pairs of the previous stage added after zero-extension (no truncation).
  // ---------------------------------------------------------------------------
  for (genvar s = 1; s <= LEVELS; s++) begin : g_lvl
    localparam int N = NUM_IN >> s;
    localparam int W = IN_W + s;
    logic [N*W-1:0]       sum_r;
    logic [2*N*(W-1)-1:0] src_s;

    if (s == 1) begin : g_src
      assign src_s = in_data;
    end else begin : g_src
      assign src_s = g_lvl[s-1].sum_r;
    end

    // Stage register: pairwise sums of the previous level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_r <= '0;
      end else begin
        for (int j = 0; j < N; j++) begin
          sum_r[j*W +: W] <= {1'b0, src_s[(2*j)*(W-1) +: (W-1)]}
                           + {1'b0, src_s[(2*j+1)*(W-1) +: (W-1)]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tags travel with the data; index i corresponds to tree stage i+1.
  // ---------------------------------------------------------------------------
  logic [LEVELS-1:0] valid_r;
  logic [LEVELS-1:0] acc_r;
  logic [LEVELS-1:0] last_r;

  // Tag shift register; a flush kills every beat in flight and the one
  // presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      acc_r   <= '0;
      last_r  <= '0;
    end else if (clr) begin
      valid_r <= '0;
      acc_r   <= '0;
      last_r  <= '0;
    end else begin
      valid_r[0] <= in_valid;
      acc_r[0]   <= in_acc;
      last_r[0]  <= in_last;
      for (int i = 1; i < LEVELS; i++) begin
        valid_r[i] <= valid_r[i-1];
        acc_r[i]   <= acc_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output / accumulator stage.
  // ---------------------------------------------------------------------------
  logic [TREE_W-1:0] tree_s;
  logic [ACC_W-1:0]  tree_ext_s;
  logic [ACC_W:0]    acc_sum_s;
  logic              v_top_s;
  logic              a_top_s;
  logic              l_top_s;

  assign tree_s     = g_lvl[LEVELS].sum_r;
  assign tree_ext_s = ACC_W'(tree_s);
  assign v_top_s    = valid_r[LEVELS-1];
  assign a_top_s    = acc_r[LEVELS-1];
  assign l_top_s    = last_r[LEVELS-1];

  logic [ACC_W-1:0] acc_r_q;
  logic             open_r;
  logic             ovf_r;
  logic [ACC_W-1:0] out_sum_r;
  logic             out_valid_r;
  logic             out_ovf_r;

  logic [ACC_W-1:0] acc_n_s;
  logic             open_n_s;
  logic             ovf_n_s;
  logic [ACC_W-1:0] out_sum_n_s;
  logic             out_valid_n_s;
  logic             out_ovf_n_s;

  assign acc_sum_s = sat_add(acc_r_q, tree_ext_s);

  // Next-state for the accumulator and output registers. Bubbles (top valid
  // tag low) leave everything untouched so their data never reaches acc.
  always_comb begin
    acc_n_s       = acc_r_q;
    open_n_s      = open_r;
    ovf_n_s       = ovf_r;
    out_sum_n_s   = out_sum_r;
    out_valid_n_s = 1'b0;
    out_ovf_n_s   = out_ovf_r;
    if (clr) begin
      acc_n_s  = '0;
      open_n_s = 1'b0;
      ovf_n_s  = 1'b0;
    end else if (v_top_s) begin
      case ({a_top_s, l_top_s})
        2'b10: begin
          acc_n_s  = acc_sum_s[ACC_W-1:0];
          open_n_s = 1'b1;
          ovf_n_s  = ovf_r | acc_sum_s[ACC_W];
        end
        2'b11: begin
          out_sum_n_s   = acc_sum_s[ACC_W-1:0];
          out_valid_n_s = 1'b1;
          out_ovf_n_s   = ovf_r | acc_sum_s[ACC_W];
          acc_n_s       = '0;
          open_n_s      = 1'b0;
          ovf_n_s       = 1'b0;
        end
        default: begin
          // Plain beat: emitted directly, open group left intact.
          out_sum_n_s   = tree_ext_s;
          out_valid_n_s = 1'b1;
          out_ovf_n_s   = 1'b0;
        end
      endcase
    end else begin
      out_valid_n_s = 1'b0;
    end
  end

  // Accumulator, group state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_q     <= '0;
      open_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_sum_r   <= '0;
      out_valid_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      acc_r_q     <= acc_n_s;
      open_r      <= open_n_s;
      ovf_r       <= ovf_n_s;
      out_sum_r   <= out_sum_n_s;
      out_valid_r <= out_valid_n_s;
      out_ovf_r   <= out_ovf_n_s;
    end
  end

  assign out_sum   = out_sum_r;
  assign out_valid = out_valid_r;
  assign out_ovf   = out_ovf_r;
  assign busy      = (|valid_r) | open_r;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc. Three instances: defaults (a),
// ACC_W=10 for saturation (b), NUM_IN=8/IN_W=6 (c). Stimulus pushes the
// hand-computed result and expected arrival cycle; a monitor pops on out_valid.
module tb_adder_tree_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // DUT a: defaults
  logic [127:0] d_a;
  logic v_a, ac_a, l_a, clr_a;
  logic [15:0] s_a;
  logic ov_a, o_a, busy_a;
  // DUT b: ACC_W=10
  logic [127:0] d_b;
  logic v_b, ac_b, l_b, clr_b;
  logic [9:0] s_b;
  logic ov_b, o_b, busy_b;
  // DUT c: NUM_IN=8, IN_W=6
  logic [47:0] d_c;
  logic v_c, ac_c, l_c, clr_c;
  logic [15:0] s_c;
  logic ov_c, o_c, busy_c;

  adder_tree_acc u_a (
    .clk(clk), .rst_n(rst_n), .in_data(d_a), .in_valid(v_a), .in_acc(ac_a),
    .in_last(l_a), .clr(clr_a), .out_sum(s_a), .out_valid(ov_a),
    .out_ovf(o_a), .busy(busy_a));

  adder_tree_acc #(.NUM_IN(32), .IN_W(4), .ACC_W(10)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(d_b), .in_valid(v_b), .in_acc(ac_b),
    .in_last(l_b), .clr(clr_b), .out_sum(s_b), .out_valid(ov_b),
    .out_ovf(o_b), .busy(busy_b));

  adder_tree_acc #(.NUM_IN(8), .IN_W(6), .ACC_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(d_c), .in_valid(v_c), .in_acc(ac_c),
    .in_last(l_c), .clr(clr_c), .out_sum(s_c), .out_valid(ov_c),
    .out_ovf(o_c), .busy(busy_c));

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [127:0] fill4(input logic [3:0] v);
    logic [127:0] r;
    for (int k = 0; k < 32; k++) r[k*4 +: 4] = v;
    return r;
  endfunction

  function automatic logic [47:0] fill6(input logic [5:0] v);
    logic [47:0] r;
    for (int k = 0; k < 8; k++) r[k*6 +: 6] = v;
    return r;
  endfunction

  // Drive one beat on DUT a at the falling edge.
  task automatic beat_a(input logic [127:0] d, input logic a, input logic l);
    @(negedge clk);
    d_a = d; v_a = 1'b1; ac_a = a; l_a = l;
  endtask
  task automatic beat_b(input logic [127:0] d, input logic a, input logic l);
    @(negedge clk);
    d_b = d; v_b = 1'b1; ac_b = a; l_b = l;
  endtask
  task automatic beat_c(input logic [47:0] d, input logic a, input logic l);
    @(negedge clk);
    d_c = d; v_c = 1'b1; ac_c = a; l_c = l;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
      ac_a = 1'b0; ac_b = 1'b0; ac_c = 1'b0;
      l_a = 1'b0; l_b = 1'b0; l_c = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    end
  endtask
  task automatic push_a(input int s, input logic o, input int lat);
    exp_t e; e.sum = 16'(s); e.ovf = o; e.at = cyc + lat; q_a.push_back(e);
  endtask
  task automatic push_b(input int s, input logic o);
    exp_t e; e.sum = 16'(s); e.ovf = o; e.at = cyc + 6; q_b.push_back(e);
  endtask
  task automatic push_c(input int s, input logic o);
    exp_t e; e.sum = 16'(s); e.ovf = o; e.at = cyc + 4; q_c.push_back(e);
  endtask

  // Monitor: every out_valid pulse must match the head of its queue,
  // including the cycle it arrives in.
  always @(negedge clk) begin
    exp_t e;
    if (ov_a) begin
      if (q_a.size() == 0) chk("a_unexpected_out", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_sum", int'(s_a), int'(e.sum));
        chk("a_ovf", int'(o_a), int'(e.ovf));
        chk("a_cycle", cyc, e.at);
      end
    end
    if (ov_b) begin
      if (q_b.size() == 0) chk("b_unexpected_out", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_sum", int'(s_b), int'(e.sum));
        chk("b_ovf", int'(o_b), int'(e.ovf));
        chk("b_cycle", cyc, e.at);
      end
    end
    if (ov_c) begin
      if (q_c.size() == 0) chk("c_unexpected_out", 1, 0);
      else begin
        e = q_c.pop_front();
        chk("c_sum", int'(s_c), int'(e.sum));
        chk("c_ovf", int'(o_c), int'(e.ovf));
        chk("c_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    logic [127:0] d;
    logic [47:0]  dc;
    int           waited;
    rst_n = 1'b0;
    d_a = '0; d_b = '0; d_c = '0;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    ac_a = 1'b0; ac_b = 1'b0; ac_c = 1'b0;
    l_a = 1'b0; l_b = 1'b0; l_c = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_sum", int'(s_a), 0);
    chk("rst_out_valid", int'(ov_a), 0);
    chk("rst_out_ovf", int'(o_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    idle(2);

    // Single beat, all lanes 0xF -> 480 after 6 cycles.
    beat_a(fill4(4'hF), 1'b0, 1'b0); push_a(480, 1'b0, 6);
    idle(1);
    chk("busy_in_flight", int'(busy_a), 1);
    idle(8);

    // Sparse lanes: only lane 31 = 15, then only lane 0 = 1.
    d = '0; d[124 +: 4] = 4'hF;
    beat_a(d, 1'b0, 1'b0); push_a(15, 1'b0, 6);
    d = '0; d[0 +: 4] = 4'h1;
    beat_a(d, 1'b0, 1'b0); push_a(1, 1'b0, 6);

    // Streaming 10 beats, lane k=(b+k)%16 -> each value twice -> 240; bubble after beat 4.
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 32; k++) d[k*4 +: 4] = 4'((b + k) % 16);
      beat_a(d, 1'b0, 1'b0); push_a(240, 1'b0, 6);
      if (b == 4) idle(1);
    end
    idle(8);

    // Accumulate group of 3 x 32 -> 96, then plain all-2 beat -> 64.
    beat_a(fill4(4'h1), 1'b1, 1'b0);
    beat_a(fill4(4'h1), 1'b1, 1'b0);
    beat_a(fill4(4'h1), 1'b1, 1'b1); push_a(96, 1'b0, 6);
    beat_a(fill4(4'h2), 1'b0, 1'b0); push_a(64, 1'b0, 6);
    idle(8);

    // Interleave: acc 32, plain 96 emitted, acc-last 32 -> group 64.
    beat_a(fill4(4'h1), 1'b1, 1'b0);
    beat_a(fill4(4'h3), 1'b0, 1'b0); push_a(96, 1'b0, 6);
    beat_a(fill4(4'h1), 1'b1, 1'b1); push_a(64, 1'b0, 6);
    idle(8);

    // Flush: 2-beat group, clr before the last beat exits; a beat
    // presented alongside clr is dropped.
    beat_a(fill4(4'h1), 1'b1, 1'b0);
    beat_a(fill4(4'h1), 1'b1, 1'b1);
    idle(2);
    @(negedge clk);
    clr_a = 1'b1; d_a = fill4(4'hF); v_a = 1'b1; ac_a = 1'b0; l_a = 1'b0;
    idle(1);
    chk("busy_after_clr", int'(busy_a), 0);
    chk("sum_held_after_clr", int'(s_a), 64);
    beat_a(fill4(4'h1), 1'b1, 1'b1); push_a(32, 1'b0, 6);
    idle(10);

    // Saturation on ACC_W=10: 3 x 480 = 1440 -> 1023 ovf; next group 32 ovf=0.
    beat_b(fill4(4'hF), 1'b1, 1'b0);
    beat_b(fill4(4'hF), 1'b1, 1'b0);
    beat_b(fill4(4'hF), 1'b1, 1'b1); push_b(1023, 1'b1);
    beat_b(fill4(4'h1), 1'b1, 1'b1); push_b(32, 1'b0);
    beat_b(fill4(4'hF), 1'b0, 1'b0); push_b(480, 1'b0);
    idle(10);

    // Reset with 4 beats in flight.
    for (int i = 0; i < 4; i++) beat_a(fill4(4'hF), 1'b0, 1'b0);
    @(negedge clk);
    v_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(ov_a), 0);
    chk("midrst_out_sum", int'(s_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    idle(2);
    rst_n = 1'b1;
    idle(10);
    beat_a(fill4(4'hF), 1'b0, 1'b0); push_a(480, 1'b0, 6);
    idle(2);

    // NUM_IN=8, IN_W=6: latency 4.
    for (int k = 0; k < 8; k++) dc[k*6 +: 6] = 6'(k * 9);
    beat_c(dc, 1'b0, 1'b0); push_c(252, 1'b0);
    beat_c(fill6(6'd63), 1'b0, 1'b0); push_c(504, 1'b0);
    beat_c(fill6(6'd63), 1'b1, 1'b0);
    beat_c(fill6(6'd63), 1'b1, 1'b1); push_c(1008, 1'b0);
    idle(1);

    // Drain with a bounded wait.
    waited = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    chk("pending_c", q_c.size(), 0);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
